// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pkg
// Description : Shared JK command encoding, sequencer FSM state encoding and
//               a next-state helper that models the synchronous JK latch.
// Revision    : 1.0  initial release
// ============================================================================
package jk_pkg;

    // JK command opcodes; bit 1 maps to J, bit 0 maps to K
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_e;

    // Sequencer FSM state encoding
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_DRIVE = 2'd1;
    localparam logic [1:0] C_ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_DRIVE = C_ST_DRIVE,
        ST_GAP   = C_ST_GAP
    } jk_state_e;

    // Latch state after one enabled edge with the given command
    function automatic logic jk_next(input logic q, input jk_op_e op);
        case (op)
            JK_HOLD: return q;
            JK_RST:  return 1'b0;
            JK_SET:  return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_fifo
// Description : Small synchronous command FIFO. Pointers carry an extra wrap
//               bit so full and empty are distinguished without a counter.
//               No write-to-read bypass: a pushed entry is visible next cycle.
// Revision    : 1.0  initial release
// ============================================================================
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Advance read/write pointers; the wrap bit rolls over naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_sequencer
// Description : Buffers JK commands and replays each on registered J/K/en for
//               cmd_hold+1 cycles followed by a one-cycle gap. Tracks the
//               expected latch output in q_exp.
//               Build option: define JK_SEQ_CHECK_EN to compare the real
//               latch output q_fb against q_exp (sticky mismatch flag).
// Revision    : 1.0  initial release
// ============================================================================
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              cmd_ready,
    output logic              J,
    output logic              K,
    output logic              en,
    output logic              busy,
    output logic              q_exp,
    input  logic              q_fb,
    output logic              mismatch
);

    localparam int C_W = 2 + HOLD_W;

    jk_state_e         r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_j;
    logic              r_k;
    logic              r_en;
    logic              r_q_exp;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [C_W-1:0]    w_head;
    logic [1:0]        w_head_op;
    logic [HOLD_W-1:0] w_head_hold;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (C_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_op, cmd_hold}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Commands are taken from IDLE, or straight out of the gap cycle
    assign w_pop       = !w_empty && (r_state == ST_IDLE || r_state == ST_GAP);
    assign w_head_op   = w_head[C_W-1:HOLD_W];
    assign w_head_hold = w_head[HOLD_W-1:0];

    assign cmd_ready = !w_full;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign J         = r_j;
    assign K         = r_k;
    assign en        = r_en;
    assign q_exp     = r_q_exp;

    // Command replay FSM with registered J/K/en
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_en       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_pop) begin
                        r_hold_cnt <= w_head_hold;
                        r_j        <= w_head_op[1];
                        r_k        <= w_head_op[0];
                        r_en       <= 1'b1;
                        r_state    <= ST_DRIVE;
                    end else begin
                        r_j     <= 1'b0;
                        r_k     <= 1'b0;
                        r_en    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (r_hold_cnt == '0) begin
                        r_j     <= 1'b0;
                        r_k     <= 1'b0;
                        r_en    <= 1'b0;
                        r_state <= ST_GAP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                    r_en    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Expected latch state: follows the latch on every enabled edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_exp <= 1'b0;
        end else if (r_en) begin
            r_q_exp <= jk_next(r_q_exp, jk_op_e'({r_j, r_k}));
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic r_q_fb;
    logic r_q_exp_d;
    logic r_mismatch;
    logic w_diff;

    assign w_diff   = (r_q_fb != r_q_exp_d);
    assign mismatch = r_mismatch | w_diff;

    // Register feedback and model side by side, then latch any difference
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_fb     <= 1'b0;
            r_q_exp_d  <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_q_fb     <= q_fb;
            r_q_exp_d  <= r_q_exp;
            r_mismatch <= r_mismatch | w_diff;
        end
    end
`else
    logic w_unused_q_fb;

    assign w_unused_q_fb = q_fb;
    assign mismatch      = 1'b0;
`endif

endmodule
`default_nettype wire
